// File: rtl/game_session_if.sv
// Handshake bundle between the game-session sequencer and the rest of the cartridge:
// key/game-logic requests in, state, run gate and BCD time out.
interface game_session_if;
    logic       key_start;
    logic       key_pause;
    logic       game_won_in;
    logic       game_over_in;
    logic       game_run;
    logic [2:0] state;
    logic       tick_1s;
    logic [3:0] time_1s;
    logic [3:0] time_10s;
    logic [3:0] time_100s;
    logic       time_max_flag;

    modport master (
        output key_start, key_pause, game_won_in, game_over_in,
        input  game_run, state, tick_1s, time_1s, time_10s, time_100s, time_max_flag
    );

    modport slave (
        input  key_start, key_pause, game_won_in, game_over_in,
        output game_run, state, tick_1s, time_1s, time_10s, time_100s, time_max_flag
    );
endinterface

// File: rtl/game_session_ctrl.sv
// Game-session sequencer: IDLE/RUN/PAUSE/WON/OVER FSM with the one-second prescaler,
// a saturating 3-digit BCD elapsed-time counter and an optional time limit.
module game_session_ctrl #(
    parameter int TICK_DIV   = 25000000,
    parameter int TIME_LIMIT = 999
) (
    input  logic             sys_clk,
    input  logic             sys_rst_n,
    game_session_if.slave    gs
);
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RUN   = 3'd1,
        S_PAUSE = 3'd2,
        S_WON   = 3'd3,
        S_OVER  = 3'd4
    } state_t;

    localparam int              PW         = $clog2(TICK_DIV);
    localparam logic [PW-1:0]   PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [3:0]      LIM_U      = 4'(TIME_LIMIT % 10);
    localparam logic [3:0]      LIM_T      = 4'((TIME_LIMIT / 10) % 10);
    localparam logic [3:0]      LIM_H      = 4'((TIME_LIMIT / 100) % 10);

    state_t          state_reg, state_next;
    logic [PW-1:0]   presc_reg, presc_next;
    logic [3:0]      digit_reg  [3];
    logic [3:0]      digit_next [3];
    logic [3:0]      digit_inc  [3];
    logic [2:0]      nine;
    logic            tick_reg, tick_next;
    logic            flag_reg, flag_next;
    logic            run_reg;
    logic            at_max;
    logic            limit_hit;

    // Digit gi advances only when every lower digit is rolling over from 9.
    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_bcd
            assign nine[gi] = (digit_reg[gi] == 4'd9);
            if (gi == 0) begin : g_lsd
                assign digit_inc[gi] = nine[gi] ? 4'd0 : digit_reg[gi] + 4'd1;
            end else begin : g_upper
                assign digit_inc[gi] = (&nine[gi-1:0])
                                     ? (nine[gi] ? 4'd0 : digit_reg[gi] + 4'd1)
                                     : digit_reg[gi];
            end
        end
    endgenerate

    assign at_max    = &nine;
    assign limit_hit = (digit_inc[2] == LIM_H) && (digit_inc[1] == LIM_T) && (digit_inc[0] == LIM_U);

    always_comb begin
        state_next = state_reg;
        presc_next = presc_reg;
        digit_next = digit_reg;
        tick_next  = 1'b0;
        flag_next  = flag_reg;
        case (state_reg)
            S_IDLE: begin
                if (gs.key_start) begin
                    state_next = S_RUN;
                    presc_next = '0;
                    digit_next = '{default: 4'd0};
                    flag_next  = 1'b0;
                end
            end
            S_RUN: begin
                if (gs.game_over_in)      state_next = S_OVER;
                else if (gs.game_won_in)  state_next = S_WON;
                else if (gs.key_pause)    state_next = S_PAUSE;
                else if (presc_reg == PRESC_LAST) begin
                    presc_next = '0;
                    tick_next  = 1'b1;
                    if (!at_max) begin
                        digit_next = digit_inc;
                        if (limit_hit) begin
                            flag_next  = 1'b1;
                            state_next = S_OVER;
                        end
                    end
                end else begin
                    presc_next = presc_reg + 1'b1;
                end
            end
            S_PAUSE: begin
                if (gs.game_over_in)      state_next = S_OVER;
                else if (gs.game_won_in)  state_next = S_WON;
                else if (gs.key_pause)    state_next = S_RUN;
            end
            S_WON, S_OVER: begin
                // Restart wins even while the game logic still holds won/over high.
                if (gs.key_start) begin
                    state_next = S_IDLE;
                    presc_next = '0;
                    digit_next = '{default: 4'd0};
                    flag_next  = 1'b0;
                end
            end
            default: begin
                state_next = S_IDLE;
                presc_next = '0;
                digit_next = '{default: 4'd0};
                flag_next  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_reg <= S_IDLE;
            presc_reg <= '0;
            digit_reg <= '{default: 4'd0};
            tick_reg  <= 1'b0;
            flag_reg  <= 1'b0;
            run_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            presc_reg <= presc_next;
            digit_reg <= digit_next;
            tick_reg  <= tick_next;
            flag_reg  <= flag_next;
            run_reg   <= (state_next == S_RUN);
        end
    end

    assign gs.state         = state_reg;
    assign gs.game_run      = run_reg;
    assign gs.tick_1s       = tick_reg;
    assign gs.time_1s       = digit_reg[0];
    assign gs.time_10s      = digit_reg[1];
    assign gs.time_100s     = digit_reg[2];
    assign gs.time_max_flag = flag_reg;
endmodule
